// File: rtl/uart_tx_seq.sv
// UART transmitter sequencer: frames one byte as start, 8 data bits LSB first,
// an optional even-parity bit and a stop bit, with a GO/EN control handshake.
module uart_tx_seq #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] ctl_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ctl_clr_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          clr_q, clr_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ctl_i == 2'b11) begin
                    sh_d    = data_i;
                    par_d   = ^data_i;
                    bit_d   = 3'd0;
                    clr_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (wrap) state_d = DATA;
            end
            DATA: begin
                if (wrap) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (wrap) state_d = STOP;
            end
            STOP: begin
                if (wrap) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx_o is registered.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign ctl_clr_o = clr_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Directed bench for uart_tx_seq: one instance without parity, one with,
// both at 4 clocks per bit.
module tb_uart_tx_seq;

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n;
    logic [1:0] ctl0, ctl1;
    logic [7:0] data0, data1;
    logic       tx0, busy0, done0, clr0;
    logic       tx1, busy1, done1, clr1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_seq #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .ctl_i(ctl0), .data_i(data0),
        .tx_o(tx0), .busy_o(busy0), .done_o(done0), .ctl_clr_o(clr0)
    );

    uart_tx_seq #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .ctl_i(ctl1), .data_i(data1),
        .tx_o(tx1), .busy_o(busy1), .done_o(done1), .ctl_clr_o(clr1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input bit which);
        if (which) begin
            chk({tag, " tx"}, {7'd0, tx1}, 8'd1);
            chk({tag, " busy"}, {7'd0, busy1}, 8'd0);
            chk({tag, " clr"}, {7'd0, clr1}, 8'd0);
        end else begin
            chk({tag, " tx"}, {7'd0, tx0}, 8'd1);
            chk({tag, " busy"}, {7'd0, busy0}, 8'd0);
            chk({tag, " clr"}, {7'd0, clr0}, 8'd0);
        end
    endtask

    // Called at the first falling edge after the start edge; returns at the
    // falling edge right after the done edge.
    task automatic check_frame(input string tag, input bit which,
                               input logic [7:0] d);
        logic [10:0] bits;
        int nb;
        logic t, b, dn, c;
        nb = which ? 11 : 10;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (which) bits[9] = ^d;
        for (int cyc = 1; cyc <= nb * 4; cyc++) begin
            if (cyc > 1) @(negedge clk);
            t  = which ? tx1 : tx0;
            b  = which ? busy1 : busy0;
            dn = which ? done1 : done0;
            c  = which ? clr1 : clr0;
            chk($sformatf("%s tx c%0d", tag, cyc), {7'd0, t}, {7'd0, bits[(cyc-1)/4]});
            chk($sformatf("%s busy c%0d", tag, cyc), {7'd0, b}, 8'd1);
            chk($sformatf("%s done c%0d", tag, cyc), {7'd0, dn}, 8'd0);
            chk($sformatf("%s clr c%0d", tag, cyc), {7'd0, c}, {7'd0, cyc == 1});
        end
        @(negedge clk);
        dn = which ? done1 : done0;
        chk({tag, " done pulse"}, {7'd0, dn}, 8'd1);
        chk_idle({tag, " done cycle"}, which);
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        ctl0 = 2'b00; ctl1 = 2'b00;
        data0 = 8'h00; data1 = 8'h00;
        repeat (2) @(negedge clk);
        chk_idle("reset0", 1'b0);
        chk_idle("reset1", 1'b1);
        chk("reset done0", {7'd0, done0}, 8'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);

        // Single frame A5, GO for one cycle
        data0 = 8'hA5; ctl0 = 2'b11;
        @(negedge clk);
        ctl0 = 2'b00;
        check_frame("A5", 1'b0, 8'hA5);
        repeat (3) @(negedge clk);
        chk_idle("A5 after", 1'b0);

        // Parity frame 07
        data1 = 8'h07; ctl1 = 2'b11;
        @(negedge clk);
        ctl1 = 2'b00;
        check_frame("P07", 1'b1, 8'h07);

        // GO without EN for 20 cycles
        ctl0 = 2'b01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_idle($sformatf("go-no-en %0d", i), 1'b0);
        end
        ctl0 = 2'b00;

        // Back-to-back with data changed mid-frame
        data0 = 8'h55; ctl0 = 2'b11;
        @(negedge clk);
        data0 = 8'h0F;
        check_frame("B2B-55", 1'b0, 8'h55);
        @(negedge clk);
        check_frame("B2B-0F", 1'b0, 8'h0F);
        ctl0 = 2'b00;
        repeat (2) @(negedge clk);
        chk_idle("B2B stop", 1'b0);

        // Reset during data bit 3 (frame bit 4)
        data0 = 8'hFF; ctl0 = 2'b11;
        @(negedge clk);
        ctl0 = 2'b00;
        repeat (17) @(negedge clk);
        chk("pre-rst busy", {7'd0, busy0}, 8'd1);
        rst0_n = 1'b0;
        #1;
        chk_idle("mid-rst", 1'b0);
        chk("mid-rst done", {7'd0, done0}, 8'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst done %0d", i), {7'd0, done0}, 8'd0);
            chk_idle($sformatf("post-rst %0d", i), 1'b0);
        end
        data0 = 8'h3C; ctl0 = 2'b11;
        @(negedge clk);
        ctl0 = 2'b00;
        check_frame("post-rst 3C", 1'b0, 8'h3C);

        // EN cleared during START, GO left set
        data0 = 8'h81; ctl0 = 2'b11;
        @(negedge clk);
        ctl0 = 2'b01;
        check_frame("EN-clr 81", 1'b0, 8'h81);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle($sformatf("EN-clr idle %0d", i), 1'b0);
        end
        ctl0 = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving the clk_i cycles per serial bit; legal range is 2..65535.
REQ-002 The block SHALL have parameter PARITY_EN, default 0; when 1, an even-parity bit is inserted after the data bits.
REQ-003 The block SHALL have port clk_i, input, 1, system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port ctl_i, input, 2, transmit control word: bit0 = GO (frame request), bit1 = EN (transmitter enable).
REQ-006 The block SHALL have port data_i, input, 8, byte to transmit; sampled only at frame start.
REQ-007 The block SHALL have port tx_o, output, 1, serial line; registered; idle level 1.
REQ-008 The block SHALL have port busy_o, output, 1, high while a frame is in progress.
REQ-009 The block SHALL have port done_o, output, 1, one-cycle pulse on frame completion.
REQ-010 The block SHALL have port ctl_clr_o, output, 1, one-cycle request to the control register owner to clear GO.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY is unreachable when PARITY_EN=0.
REQ-012 In IDLE, if ctl_i == 2'b11 at a rising edge, the FSM SHALL at that edge latch data_i into a shift register, load the bit counter with 0, load the baud counter with 0, and enter START.
REQ-013 In IDLE, ctl_i of 2'b01, 2'b10 or 2'b00 SHALL leave the state unchanged; a GO bit with EN=0 does not start a frame.
REQ-014 On the start edge, ctl_clr_o SHALL be 1 for exactly the following cycle and 0 at all other times.
REQ-015 tx_o SHALL be driven registered: 0 in START, shift-register bit0 in DATA, parity in PARITY, and 1 in STOP and IDLE.
REQ-016 Each of START, DATA (per bit), PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and clears on wrap.
REQ-017 DATA SHALL emit 8 bits LSB first, shifting right on each baud wrap; after the 8th bit the FSM SHALL go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-018 The parity bit SHALL be the XOR of the 8 latched data bits (even parity).
REQ-019 On the baud wrap in STOP, the FSM SHALL enter IDLE and assert done_o for exactly the next cycle.
REQ-020 Total frame length from the start edge to the done_o pulse SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-021 busy_o SHALL be 1 in every non-IDLE state and 0 in IDLE, including during the done_o cycle.
REQ-022 Changes on data_i or ctl_i during a frame SHALL NOT affect the frame in progress; clearing EN mid-frame SHALL NOT abort the frame.
REQ-023 If ctl_i == 2'b11 is still present on the first IDLE edge after completion, a new frame SHALL start on that edge; back-to-back frames are thus separated by exactly one idle cycle at tx_o=1.
REQ-024 The baud counter width SHALL be clog2(CLKS_PER_BIT), and the counter SHALL never exceed CLKS_PER_BIT-1.

Reset
REQ-025 On rst_ni low, regardless of state, the block SHALL immediately enter IDLE with tx_o=1, busy_o=0, done_o=0, ctl_clr_o=0, and counters and shift register cleared.
REQ-026 A reset asserted mid-frame SHALL truncate the frame with no done_o pulse; after release the block SHALL wait in IDLE for a fresh GO.

Verification
REQ-027 Single frame, CLKS_PER_BIT=4, PARITY_EN=0, data_i=8'hA5, ctl_i=11 for one cycle -> ctl_clr_o pulses once; tx_o = 0,1,0,1,0,0,1,0,1,1 with each bit lasting 4 cycles; done_o is pulsed 40 cycles after the start edge.
REQ-028 Same setup with PARITY_EN=1 and data_i=8'h07 -> the parity bit is 1; the frame lasts 44 cycles; the stop bit is 1.
REQ-029 ctl_i=01 held for 20 cycles -> tx_o stays 1, busy_o stays 0, and ctl_clr_o stays 0.
REQ-030 ctl_i held at 11 over two frames, data_i changed mid-frame from 8'h55 to 8'h0F -> the first frame carries 8'h55; after done_o there is one idle cycle, then the second frame carries 8'h0F.
REQ-031 rst_ni pulsed low during DATA bit 3 -> tx_o=1 and busy_o=0 immediately, with no done_o; a later GO produces a complete frame.
REQ-032 EN cleared during START -> the frame completes normally with done_o; no new frame starts.
